fft_frame_sequencer: RTL and testbench
======================================

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 Parameter LOG2N, default 9, log2 of FFT points N (N = 2**LOG2N).
REQ-002 Parameter DW, default 16, width of each real/imag component; sample word = {re, im}, 2*DW bits, re in the upper half.
REQ-003 clk  in  1  single clock, all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 flush  in  1  synchronous abort of the current frame.
REQ-006 s_valid / s_ready / s_data  in / out / in  1 / 1 / 2*DW  input sample stream.
REQ-007 fft_load  out  1  level: core in load mode.
REQ-008 fft_we / fft_load_address / fft_data_in  out  1 / LOG2N / 2*DW  core sample write port.
REQ-009 fft_start  out  1  one-cycle start pulse.
REQ-010 fft_done  in  1  core results ready, level, held until next fft_start.
REQ-011 fft_rd_address / fft_data_out  out / in  LOG2N / 2*DW  core result read port, data valid one cycle after address.
REQ-012 m_valid / m_ready / m_data / m_index / m_last  out / in / out / out / out  1 / 1 / 2*DW / LOG2N / 1  result stream.
REQ-013 busy  out  1  high in every state except LOAD.
REQ-014 peak_valid / peak_index / peak_mag  out / out / out  1 / LOG2N / DW+1  frame peak report.

Function
REQ-015 FSM states LOAD, START, WAIT, UNLOAD; LOAD→START after N-th sample handshake, START→WAIT after one cycle, WAIT→UNLOAD on fft_done=1, UNLOAD→LOAD after beat with m_last accepted.
REQ-016 LOAD: s_ready=1, fft_load=1; each s_valid&&s_ready registers fft_we=1, fft_load_address=sample count, fft_data_in=s_data on the next cycle; count wraps N-1→0.
REQ-017 fft_start asserted exactly one cycle in START, no earlier than the cycle after the last fft_we.
REQ-018 s_ready=0 outside LOAD; fft_load=0 outside LOAD and START.
REQ-019 UNLOAD: read address advances 0..N-1 in order; at most one read outstanding; read k+1 issued in the cycle beat k is accepted.
REQ-020 m_data captured from fft_data_out one cycle after address issue; m_valid then held with m_data, m_index, m_last stable until m_ready=1.
REQ-021 Back-to-back beats with m_ready held high: m_valid low exactly one cycle between beats (2 cycles per result).
REQ-022 m_last=1 only with m_index=N-1.
REQ-023 flush=1 in any state: next cycle in LOAD, counts zeroed, m_valid=0, no fft_start issued, partial peak discarded; flush has priority over every simultaneous handshake.
REQ-024 fft_done=1 outside WAIT ignored.

Reset
REQ-025 reset asserted: state=LOAD, counts=0, fft_we=0, fft_start=0, m_valid=0, m_last=0, peak_valid=0, all data/address/index outputs=0, immediately and independent of clk.
REQ-026 reset mid-frame discards all loaded samples and pending results; first post-reset sample written to address 0.

Configuration
REQ-027 Macro FFT_PEAK_DETECT_EN defined: per accepted result, mag=|re|+|im| (DW+1 bits, unsigned, no saturation); bin 0 excluded; strictly greater replaces peak (ties keep lowest index); peak_valid pulses one cycle the cycle after m_last beat accepted, peak_index/peak_mag held until next pulse.
REQ-028 Macro undefined: no peak logic; peak_valid, peak_index, peak_mag tied to 0; ports retained.

Verification
REQ-029 LOG2N=3, samples 0x00010000..0x00080000, m_ready=1 -> fft_we at addresses 0..7 in order, single fft_start, no fft_start before last write.
REQ-030 Core model returns word k at address k after fft_done -> m_index 0..7, m_data matches, m_last only on index 7, 2 cycles per beat, busy low afterward.
REQ-031 m_ready low 5 cycles during beat 3 -> m_data/m_index stable, no fft_rd_address advance, no dropped or repeated beat.
REQ-032 flush after 4 samples, together with s_valid -> that sample not written, next sample written to address 0, no fft_start.
REQ-033 reset asserted in WAIT, then 8 new samples -> outputs zero during reset, new frame starts at address 0, old fft_done ignored.
REQ-034 FFT_PEAK_DETECT_EN, results bin0=0x7FFF7FFF, bin2=0x0010FFF0, bin5=0xFFE00000 (mag 0x20, 0x20) -> peak_index=2, peak_mag=0x020, single peak_valid pulse.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: frames an input sample stream into an N-point FFT core,
// starts the transform, then streams the results back out in bin order.
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   flush             : synchronous abort of the frame in progress
//   s_valid/s_ready/s_data : input samples {re, im}, accepted only in LOAD
//   fft_load, fft_we, fft_load_address, fft_data_in : core load port
//   fft_start / fft_done   : one-cycle start pulse / core results-ready level
//   fft_rd_address / fft_data_out : core result read port (one-cycle latency)
//   m_valid/m_ready/m_data/m_index/m_last : result stream, one beat per bin
//   busy              : high whenever the sequencer is not accepting samples
//   peak_valid/peak_index/peak_mag : per-frame peak report
//
// Optional feature: define FFT_PEAK_DETECT_EN to build the peak detector
// (|re|+|im| magnitude, bin 0 excluded, ties keep the lowest bin). Without it
// the peak outputs are tied to zero.

module fft_frame_sequencer #(
  parameter int unsigned LOG2N = 9,
  parameter int unsigned DW    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [2*DW-1:0]      s_data,
  output logic                 fft_load,
  output logic                 fft_we,
  output logic [LOG2N-1:0]     fft_load_address,
  output logic [2*DW-1:0]      fft_data_in,
  output logic                 fft_start,
  input  logic                 fft_done,
  output logic [LOG2N-1:0]     fft_rd_address,
  input  logic [2*DW-1:0]      fft_data_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*DW-1:0]      m_data,
  output logic [LOG2N-1:0]     m_index,
  output logic                 m_last,
  output logic                 busy,
  output logic                 peak_valid,
  output logic [LOG2N-1:0]     peak_index,
  output logic [DW:0]          peak_mag
);

  localparam int unsigned SW = 2 * DW;
  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  state_t           state;
  logic [LOG2N-1:0] cnt;
  // cap: fft_data_out holds the bin addressed by fft_rd_address this cycle
  logic             cap;

  // Frame sequencer FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= LOAD;
      cnt              <= '0;
      cap              <= 1'b0;
      s_ready          <= 1'b1;
      fft_load         <= 1'b1;
      busy             <= 1'b0;
      fft_we           <= 1'b0;
      fft_load_address <= '0;
      fft_data_in      <= '0;
      fft_start        <= 1'b0;
      fft_rd_address   <= '0;
      m_valid          <= 1'b0;
      m_data           <= '0;
      m_index          <= '0;
      m_last           <= 1'b0;
    end else begin
      fft_we    <= 1'b0;
      fft_start <= 1'b0;
      if (flush) begin
        state          <= LOAD;
        cnt            <= '0;
        cap            <= 1'b0;
        s_ready        <= 1'b1;
        fft_load       <= 1'b1;
        busy           <= 1'b0;
        fft_rd_address <= '0;
        m_valid        <= 1'b0;
        m_last         <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (s_valid) begin
              fft_we           <= 1'b1;
              fft_load_address <= cnt;
              fft_data_in      <= s_data;
              cnt              <= cnt + LOG2N'(1);
              if (cnt == LAST_IDX) begin
                state   <= START;
                s_ready <= 1'b0;
                busy    <= 1'b1;
              end
            end
          end
          // The last write is on the port during this cycle; start follows it
          START: begin
            fft_start <= 1'b1;
            fft_load  <= 1'b0;
            state     <= WAIT;
          end
          // fft_done from the previous frame may still be high while start is out
          WAIT: begin
            if (fft_done && !fft_start) begin
              state <= UNLOAD;
              cap   <= 1'b1;
            end
          end
          // Read address is prefetched at capture so each beat costs two cycles
          UNLOAD: begin
            if (cap) begin
              cap            <= 1'b0;
              m_valid        <= 1'b1;
              m_data         <= fft_data_out;
              m_index        <= fft_rd_address;
              m_last         <= (fft_rd_address == LAST_IDX);
              fft_rd_address <= fft_rd_address + LOG2N'(1);
            end else if (m_valid && m_ready) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              if (m_last) begin
                state    <= LOAD;
                s_ready  <= 1'b1;
                fft_load <= 1'b1;
                busy     <= 1'b0;
              end else begin
                cap <= 1'b1;
              end
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

`ifdef FFT_PEAK_DETECT_EN
  function automatic logic [DW-1:0] abs_val(input logic [DW-1:0] x);
    return x[DW-1] ? (~x + DW'(1)) : x;
  endfunction

  logic [DW:0]      mag_c;
  logic             beat_accept_c;
  logic             better_c;
  logic [DW:0]      best_mag;
  logic [LOG2N-1:0] best_idx;

  assign mag_c         = {1'b0, abs_val(m_data[SW-1:DW])} + {1'b0, abs_val(m_data[DW-1:0])};
  assign beat_accept_c = m_valid && m_ready && !flush;
  assign better_c      = (m_index != '0) && (mag_c > best_mag);

  // Running peak over accepted beats; reported one cycle after the last beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_mag   <= '0;
      best_idx   <= '0;
      peak_valid <= 1'b0;
      peak_index <= '0;
      peak_mag   <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (flush) begin
        best_mag <= '0;
        best_idx <= '0;
      end else if (beat_accept_c) begin
        if (m_last) begin
          peak_valid <= 1'b1;
          peak_index <= better_c ? m_index : best_idx;
          peak_mag   <= better_c ? mag_c : best_mag;
          best_mag   <= '0;
          best_idx   <= '0;
        end else if (better_c) begin
          best_mag <= mag_c;
          best_idx <= m_index;
        end
      end
    end
  end
`else
  assign peak_valid = 1'b0;
  assign peak_index = '0;
  assign peak_mag   = '0;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer (LOG2N=3, DW=16) with an
// identity FFT core model: result bin k equals loaded sample k.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;
  localparam int unsigned LOG2N = 3;
  localparam int unsigned DW    = 16;
  localparam int unsigned N     = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        fft_load, fft_we, fft_start;
  logic [2:0]  fft_load_address, fft_rd_address;
  logic [31:0] fft_data_in;
  logic        fft_done = 1'b0;
  logic [31:0] fft_data_out;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic [2:0]  m_index;
  logic        m_last, busy, peak_valid;
  logic [2:0]  peak_index;
  logic [16:0] peak_mag;

  always #5 clk = ~clk;

  fft_frame_sequencer #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fft_load(fft_load), .fft_we(fft_we), .fft_load_address(fft_load_address),
    .fft_data_in(fft_data_in), .fft_start(fft_start), .fft_done(fft_done),
    .fft_rd_address(fft_rd_address), .fft_data_out(fft_data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .busy(busy),
    .peak_valid(peak_valid), .peak_index(peak_index), .peak_mag(peak_mag)
  );

  // Identity core model; done rises 5 cycles after start and holds until next start
  logic [31:0] load_mem [N];
  logic [31:0] res_mem  [N];
  int          done_cnt = 0;
  always @(posedge clk) begin
    if (fft_we) load_mem[fft_load_address] <= fft_data_in;
    fft_data_out <= res_mem[fft_rd_address];
    if (fft_start) begin
      fft_done <= 1'b0;
      done_cnt <= 5;
      for (int k = 0; k < N; k++) res_mem[k] <= load_mem[k];
    end else if (done_cnt != 0) begin
      done_cnt <= done_cnt - 1;
      if (done_cnt == 1) fft_done <= 1'b1;
    end
  end

  typedef struct {
    logic [N-1:0][31:0] smp;
    int                 stall_beat;
    int                 stall_len;
    bit                 gaps;
    logic [2:0]         pk_idx;
    logic [16:0]        pk_mag;
  } vec_t;
  vec_t vecs[4];

  typedef struct packed { logic [2:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [2:0] idx; logic [31:0] data; logic last; } beat_t;
  typedef struct packed { logic [2:0] idx; logic [16:0] mag; } pk_t;
  wr_t   wr_q[$];
  beat_t beat_q[$];
  pk_t   pk_q[$];
  wr_t   w_exp;
  beat_t b_exp;
  pk_t   p_exp;

  int tests = 0;
  int fails = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  int cur_stall_beat = -1;
  int cur_stall_len  = 0;
  int stall_done     = 0;
  // Back-pressure: hold m_ready low on the chosen beat for the chosen length
  always @(posedge clk) begin
    #1;
    if (!busy) stall_done = 0;
    if (m_valid && int'(m_index) == cur_stall_beat && stall_done < cur_stall_len) begin
      m_ready = 1'b0;
      stall_done++;
    end else begin
      m_ready = 1'b1;
    end
  end

  int          last_acc  = 0;
  int          start_cnt = 0;
  int          pk_cnt    = 0;
  logic        stalled   = 1'b0;
  logic [31:0] st_data;
  logic [2:0]  st_idx, st_rd;

  // Monitor: pops scoreboard entries as the DUT produces writes, beats and peaks
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (fft_we) begin
        if (wr_q.size() == 0) check("unexpected_write", 64'(fft_load_address), 64'hFFFF);
        else begin
          w_exp = wr_q.pop_front();
          check("wr_addr", 64'(fft_load_address), 64'(w_exp.addr));
          check("wr_data", 64'(fft_data_in), 64'(w_exp.data));
        end
      end
      if (fft_start) begin
        start_cnt++;
        check("start_before_last_write", 64'(wr_q.size()), 64'd0);
      end
      if (stalled) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_data", 64'(m_data), 64'(st_data));
        check("stall_index", 64'(m_index), 64'(st_idx));
        check("stall_rd_addr", 64'(fft_rd_address), 64'(st_rd));
      end
      stalled = m_valid && !m_ready;
      st_data = m_data;
      st_idx  = m_index;
      st_rd   = fft_rd_address;
      if (m_valid && m_ready) begin
        if (beat_q.size() == 0) check("unexpected_beat", 64'(m_index), 64'hFFFF);
        else begin
          b_exp = beat_q.pop_front();
          check("beat_index", 64'(m_index), 64'(b_exp.idx));
          check("beat_data", 64'(m_data), 64'(b_exp.data));
          check("beat_last", 64'(m_last), 64'(b_exp.last));
          if (b_exp.idx != 3'd0)
            check("beat_spacing", 64'(cyc - last_acc),
                  64'(2 + ((int'(b_exp.idx) == cur_stall_beat) ? cur_stall_len : 0)));
        end
        last_acc = cyc;
      end
      if (peak_valid) begin
        pk_cnt++;
        check("peak_timing", 64'(cyc - last_acc), 64'd1);
        if (pk_q.size() == 0) check("unexpected_peak", 64'(peak_index), 64'hFFFF);
        else begin
          p_exp = pk_q.pop_front();
          check("peak_index", 64'(peak_index), 64'(p_exp.idx));
          check("peak_mag", 64'(peak_mag), 64'(p_exp.mag));
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_fft_we"}, 64'(fft_we), 64'd0);
    check({tag, "_fft_start"}, 64'(fft_start), 64'd0);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_last"}, 64'(m_last), 64'd0);
    check({tag, "_peak_valid"}, 64'(peak_valid), 64'd0);
    check({tag, "_addrs"}, 64'({fft_load_address, fft_rd_address, m_index, peak_index}), 64'd0);
    check({tag, "_data"}, {fft_data_in, m_data}, 64'd0);
    check({tag, "_peak_mag"}, 64'(peak_mag), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_load_ready"}, 64'({fft_load, s_ready}), 64'd3);
  endtask

  task automatic drive_sample(input logic [31:0] d);
    check("s_ready_in_load", 64'(s_ready), 64'd1);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic load_samples(input vec_t v, input bit with_results);
    beat_t b;
    wr_t   w;
    for (int k = 0; k < N; k++) begin
      w.addr = 3'(k);
      w.data = v.smp[k];
      wr_q.push_back(w);
      if (with_results) begin
        b.idx  = 3'(k);
        b.data = v.smp[k];
        b.last = (k == N - 1);
        beat_q.push_back(b);
      end
    end
`ifdef FFT_PEAK_DETECT_EN
    if (with_results) begin
      p_exp.idx = v.pk_idx;
      p_exp.mag = v.pk_mag;
      pk_q.push_back(p_exp);
    end
`endif
    cur_stall_beat = v.stall_beat;
    cur_stall_len  = v.stall_len;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (v.gaps && k[0]) begin
        @(posedge clk);
        #1;
      end
      drive_sample(v.smp[k]);
    end
  endtask

  task automatic wait_frame_end();
    int n = 0;
    @(negedge clk);
    while ((beat_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", 64'(n < 400), 64'd1);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_ready", 64'({s_ready, fft_load}), 64'd3);
    check("writes_left", 64'(wr_q.size()), 64'd0);
    check("peaks_left", 64'(pk_q.size()), 64'd0);
  endtask

  int s0, p0, n;

  initial begin
    for (int k = 0; k < N; k++) begin
      vecs[0].smp[k] = 32'((k + 1) << 16);
      vecs[1].smp[k] = 32'((k + 1) << 16);
      vecs[2].smp[k] = '0;
      vecs[3].smp[k] = '0;
    end
    vecs[0].stall_beat = -1; vecs[0].stall_len = 0; vecs[0].gaps = 0;
    vecs[0].pk_idx = 3'd7;   vecs[0].pk_mag = 17'h00008;
    vecs[1].stall_beat = 3;  vecs[1].stall_len = 5; vecs[1].gaps = 1;
    vecs[1].pk_idx = 3'd7;   vecs[1].pk_mag = 17'h00008;
    vecs[2].smp[0] = 32'h7FFF7FFF;
    vecs[2].smp[2] = 32'h0010FFF0;
    vecs[2].smp[5] = 32'hFFE00000;
    vecs[2].stall_beat = -1; vecs[2].stall_len = 0; vecs[2].gaps = 0;
    vecs[2].pk_idx = 3'd2;   vecs[2].pk_mag = 17'h00020;
    vecs[3].smp[1] = 32'h00050003;
    vecs[3].smp[3] = 32'hFFFF0001;
    vecs[3].smp[4] = 32'h80000000;
    vecs[3].smp[6] = 32'h80000001;
    vecs[3].smp[7] = 32'h7FFF0002;
    vecs[3].stall_beat = 6;  vecs[3].stall_len = 2; vecs[3].gaps = 1;
    vecs[3].pk_idx = 3'd6;   vecs[3].pk_mag = 17'h08001;

    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    @(negedge clk);
    reset = 1'b0;

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      s0 = start_cnt;
      p0 = pk_cnt;
      load_samples(vecs[i], 1'b1);
      wait_frame_end();
      check("start_count", 64'(start_cnt - s0), 64'd1);
`ifdef FFT_PEAK_DETECT_EN
      check("peak_pulses", 64'(pk_cnt - p0), 64'd1);
`else
      check("peak_pulses", 64'(pk_cnt - p0), 64'd0);
      check("peak_tied", 64'({peak_index, peak_mag}), 64'd0);
`endif
    end

    // Flush after 4 samples, coincident with a fifth handshake
    s0 = start_cnt;
    for (int k = 0; k < 4; k++) begin
      w_exp.addr = 3'(k);
      w_exp.data = 32'hA000_0000 | 32'(k);
      wr_q.push_back(w_exp);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) drive_sample(32'hA000_0000 | 32'(k));
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    flush   = 1'b0;
    s_valid = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_m_valid", 64'(m_valid), 64'd0);
    load_samples(vecs[2], 1'b1);
    wait_frame_end();
    check("flush_start_count", 64'(start_cnt - s0), 64'd1);

    // Asynchronous reset while waiting on the core; stale fft_done must be ignored
    s0 = start_cnt;
    load_samples(vecs[0], 1'b0);
    n = 0;
    while (start_cnt == s0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_start_seen", 64'(start_cnt - s0), 64'd1);
    @(posedge clk);
    #3;
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    reset_checks("async");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("stale_done_busy", 64'(busy), 64'd0);
    check("stale_done_m_valid", 64'(m_valid), 64'd0);
    load_samples(vecs[3], 1'b1);
    wait_frame_end();
    check("post_reset_start_count", 64'(start_cnt - s0), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
